// File: rtl/seq_detector_param_if.sv
// Bus bundle for the parametrised serial pattern detector: sample/control inputs
// plus match flag, depth and counter outputs.
interface seq_detector_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int SW = $clog2(PAT_LEN);

    logic               en;
    logic               x;
    logic               load_pat;
    logic [PAT_LEN-1:0] pattern;
    logic               clr_cnt;
    logic               y;
    logic [SW-1:0]      cs;
    logic [SW-1:0]      ns;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output en, x, load_pat, pattern, clr_cnt,
        input  y, cs, ns, match_cnt, cnt_sat
    );

    modport slave (
        input  en, x, load_pat, pattern, clr_cnt,
        output y, cs, ns, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Mealy detector for a runtime-loadable PAT_LEN-bit pattern on a serial stream,
// with overlapping/non-overlapping restart and a saturating match counter.
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] RST_PAT = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input logic                clk,
    input logic                rst,
    seq_detector_param_if.slave bus
);
    localparam int               SW      = $clog2(PAT_LEN);
    localparam int               DW      = $clog2(PAT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] r_pat;
    logic [PAT_LEN-2:0] r_hist;
    logic [SW-1:0]      r_cs;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;

    logic [PAT_LEN-1:0] w_cat;
    logic [PAT_LEN:1]   w_match;
    logic [DW-1:0]      w_d;
    logic [DW-1:0]      w_d_ov;
    logic               w_y;
    logic [SW-1:0]      w_ns;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_sat_next;

    // Newest bit sits at the LSB, so the low k bits are the last k accepted bits.
    assign w_cat = {r_hist, bus.x};

    generate
        for (genvar gi = 1; gi <= PAT_LEN; gi++) begin : g_sfx
            assign w_match[gi] = (w_cat[gi-1:0] == r_pat[PAT_LEN-1 -: gi]);
        end
    endgenerate

    // Bounding k by cs+1 keeps zeroed or stale history from faking a prefix.
    always_comb begin
        w_d    = '0;
        w_d_ov = '0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            if (w_match[k] && (k <= int'(r_cs) + 1)) begin
                w_d = DW'(k);
                if (k < PAT_LEN) begin
                    w_d_ov = DW'(k);
                end
            end
        end
    end

    assign w_y = rst & bus.en & ~bus.load_pat & (w_d == DW'(PAT_LEN));

    always_comb begin
        w_ns = r_cs;
        if (!rst || bus.load_pat) begin
            w_ns = '0;
        end else if (bus.en) begin
            if (w_d != DW'(PAT_LEN)) begin
                w_ns = SW'(w_d);
            end else if (OVERLAP) begin
                w_ns = SW'(w_d_ov);
            end else begin
                w_ns = '0;
            end
        end
    end

    // A clear coinciding with a match leaves that match counted.
    always_comb begin
        w_cnt_next = r_cnt;
        w_sat_next = r_sat;
        if (bus.clr_cnt) begin
            w_cnt_next = w_y ? CNT_W'(1) : '0;
            w_sat_next = 1'b0;
        end else if (w_y && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        if (w_cnt_next == CNT_MAX) begin
            w_sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat  <= RST_PAT;
            r_hist <= '0;
            r_cs   <= '0;
            r_cnt  <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (bus.load_pat) begin
                r_pat  <= bus.pattern;
                r_hist <= '0;
                r_cs   <= '0;
            end else if (bus.en) begin
                r_hist <= w_cat[PAT_LEN-2:0];
                r_cs   <= w_ns;
            end
            r_cnt <= w_cnt_next;
            r_sat <= w_sat_next;
        end
    end

    assign bus.y         = w_y;
    assign bus.cs        = r_cs;
    assign bus.ns        = w_ns;
    assign bus.match_cnt = r_cnt;
    assign bus.cnt_sat   = r_sat;
endmodule

// File: tb/tb_seq_detector_param.sv
// Four detector configurations driven by one stream and checked against a
// prefix/suffix model of the accepted bits since the last restart.
module tb_seq_detector_param;
    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic       x        = 1'b0;
    logic       load_pat = 1'b0;
    logic       clr_cnt  = 1'b0;
    logic [3:0] pat4     = 4'b1011;
    logic [2:0] pat3     = 3'b111;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) if_a ();
    seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) if_b ();
    seq_detector_param_if #(.PAT_LEN(3), .CNT_W(2)) if_c ();
    seq_detector_param_if #(.PAT_LEN(3), .CNT_W(2)) if_d ();

    assign if_a.en = en;  assign if_a.x = x;  assign if_a.load_pat = load_pat;
    assign if_a.clr_cnt = clr_cnt;  assign if_a.pattern = pat4;
    assign if_b.en = en;  assign if_b.x = x;  assign if_b.load_pat = load_pat;
    assign if_b.clr_cnt = clr_cnt;  assign if_b.pattern = pat4;
    assign if_c.en = en;  assign if_c.x = x;  assign if_c.load_pat = load_pat;
    assign if_c.clr_cnt = clr_cnt;  assign if_c.pattern = pat3;
    assign if_d.en = en;  assign if_d.x = x;  assign if_d.load_pat = load_pat;
    assign if_d.clr_cnt = clr_cnt;  assign if_d.pattern = pat3;

    seq_detector_param #(.PAT_LEN(4), .RST_PAT(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    seq_detector_param #(.PAT_LEN(4), .RST_PAT(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    seq_detector_param #(.PAT_LEN(3), .RST_PAT(3'b111), .OVERLAP(1'b1), .CNT_W(2))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    seq_detector_param #(.PAT_LEN(3), .RST_PAT(3'b111), .OVERLAP(1'b0), .CNT_W(2))
        dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

    wire [3:0]      obs_y   = {if_d.y, if_c.y, if_b.y, if_a.y};
    wire [3:0]      obs_sat = {if_d.cnt_sat, if_c.cnt_sat, if_b.cnt_sat, if_a.cnt_sat};
    wire [3:0][7:0] obs_cs  = {{6'd0, if_d.cs}, {6'd0, if_c.cs}, {6'd0, if_b.cs}, {6'd0, if_a.cs}};
    wire [3:0][7:0] obs_ns  = {{6'd0, if_d.ns}, {6'd0, if_c.ns}, {6'd0, if_b.ns}, {6'd0, if_a.ns}};
    wire [3:0][7:0] obs_cnt = {{6'd0, if_d.match_cnt}, {6'd0, if_c.match_cnt},
                               if_b.match_cnt, if_a.match_cnt};

    // Model state: pattern, accepted bits since last restart (newest at bit 0), counters.
    logic [15:0] m_pat [4];
    logic [31:0] m_str [4];
    int          m_n   [4];
    int          m_cnt [4];
    logic        m_sat [4];
    logic        e_y   [4];
    int          e_ns  [4];
    int          e_cs  [4];
    int          e_cnt [4];
    logic        e_sat [4];
    logic        s_y   [4];
    logic [7:0]  s_ns  [4];
    logic [7:0]  s_cs  [4];
    logic [7:0]  s_cnt [4];
    logic        s_sat [4];

    function automatic int len_of(input int i);
        return (i < 2) ? 4 : 3;
    endfunction

    function automatic bit ov_of(input int i);
        return (i % 2) == 0;
    endfunction

    function automatic int cmax_of(input int i);
        return (i < 2) ? 255 : 3;
    endfunction

    // Longest k <= min(n, kmax) whose last k stream bits spell the pattern's first k bits.
    function automatic int best_k(input int i, input logic [31:0] s, input int n, input int kmax);
        int L;
        int lim;
        int best;
        bit ok;
        L    = len_of(i);
        lim  = (n < kmax) ? n : kmax;
        best = 0;
        for (int k = 1; k <= lim; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (s[j] !== m_pat[i][L-k+j]) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pat[i] = (i < 2) ? 16'b1011 : 16'b111;
            m_str[i] = '0;
            m_n[i]   = 0;
            m_cnt[i] = 0;
            m_sat[i] = 1'b0;
        end
    endtask

    task automatic model_eval();
        int L;
        int d;
        logic [31:0] s2;
        for (int i = 0; i < 4; i++) begin
            L = len_of(i);
            if (load_pat) begin
                e_y[i]  = 1'b0;
                e_ns[i] = 0;
            end else if (!en) begin
                e_y[i]  = 1'b0;
                e_ns[i] = best_k(i, m_str[i], m_n[i], L - 1);
            end else begin
                s2     = {m_str[i][30:0], x};
                d      = best_k(i, s2, m_n[i] + 1, L);
                e_y[i] = (d == L);
                if (d < L)          e_ns[i] = d;
                else if (ov_of(i))  e_ns[i] = best_k(i, s2, m_n[i] + 1, L - 1);
                else                e_ns[i] = 0;
            end
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < 4; i++) begin
            if (load_pat) begin
                m_pat[i] = (i < 2) ? {12'd0, pat4} : {13'd0, pat3};
                m_str[i] = '0;
                m_n[i]   = 0;
            end else if (en) begin
                m_str[i] = {m_str[i][30:0], x};
                if (m_n[i] < 16) m_n[i]++;
                if (e_y[i] && !ov_of(i)) m_n[i] = 0;
            end
            if (clr_cnt) begin
                m_cnt[i] = e_y[i] ? 1 : 0;
                m_sat[i] = 1'b0;
            end else if (e_y[i] && m_cnt[i] < cmax_of(i)) begin
                m_cnt[i]++;
            end
            if (m_cnt[i] == cmax_of(i)) m_sat[i] = 1'b1;
            e_cs[i]  = best_k(i, m_str[i], m_n[i], len_of(i) - 1);
            e_cnt[i] = m_cnt[i];
            e_sat[i] = m_sat[i];
        end
    endtask

    task automatic run_cycle(input logic i_en, input logic i_x, input logic i_load, input logic i_clr);
        @(negedge clk);
        en = i_en; x = i_x; load_pat = i_load; clr_cnt = i_clr;
        #2;
        model_eval();
        for (int i = 0; i < 4; i++) begin
            s_y[i]  = obs_y[i];
            s_ns[i] = obs_ns[i];
        end
        @(posedge clk);
        #1;
        model_tick();
        for (int i = 0; i < 4; i++) begin
            s_cs[i]  = obs_cs[i];
            s_cnt[i] = obs_cnt[i];
            s_sat[i] = obs_sat[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; x = 1'b0; load_pat = 1'b0; clr_cnt = 1'b0;
        pat4 = 4'b1011; pat3 = 3'b111;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        en = 1'b1; x = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks += 5;
            if (obs_y[i] !== 1'b0) begin n_fail++; $display("FAIL reset_y inst%0d: got %0b expected 0", i, obs_y[i]); end
            if (obs_ns[i] !== 8'd0) begin n_fail++; $display("FAIL reset_ns inst%0d: got %0d expected 0", i, obs_ns[i]); end
            if (obs_cs[i] !== 8'd0) begin n_fail++; $display("FAIL reset_cs inst%0d: got %0d expected 0", i, obs_cs[i]); end
            if (obs_cnt[i] !== 8'd0) begin n_fail++; $display("FAIL reset_cnt inst%0d: got %0d expected 0", i, obs_cnt[i]); end
            if (obs_sat[i] !== 1'b0) begin n_fail++; $display("FAIL reset_sat inst%0d: got %0b expected 0", i, obs_sat[i]); end
        end
        @(negedge clk);
        rst = 1'b1; en = 1'b0; x = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        logic [6:0] ya;
        logic [6:0] yb;
        int csa [7];
        bits = 7'b1011011; ya = 7'b0001001; yb = 7'b0001000;
        csa  = '{1, 2, 3, 1, 2, 3, 1};
        do_reset();
        for (int j = 0; j < 7; j++) begin
            run_cycle(1'b1, bits[6-j], 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_checks += 5;
                if (s_y[i] !== e_y[i]) begin n_fail++; $display("FAIL overlap_y inst%0d step%0d: got %0b expected %0b", i, j, s_y[i], e_y[i]); end
                if (s_ns[i] !== 8'(e_ns[i])) begin n_fail++; $display("FAIL overlap_ns inst%0d step%0d: got %0d expected %0d", i, j, s_ns[i], e_ns[i]); end
                if (s_cs[i] !== 8'(e_cs[i])) begin n_fail++; $display("FAIL overlap_cs inst%0d step%0d: got %0d expected %0d", i, j, s_cs[i], e_cs[i]); end
                if (s_cnt[i] !== 8'(e_cnt[i])) begin n_fail++; $display("FAIL overlap_cnt inst%0d step%0d: got %0d expected %0d", i, j, s_cnt[i], e_cnt[i]); end
                if (s_sat[i] !== e_sat[i]) begin n_fail++; $display("FAIL overlap_sat inst%0d step%0d: got %0b expected %0b", i, j, s_sat[i], e_sat[i]); end
            end
            n_checks += 3;
            if (s_y[0] !== ya[6-j]) begin n_fail++; $display("FAIL overlap_a_y step%0d: got %0b expected %0b", j, s_y[0], ya[6-j]); end
            if (s_y[1] !== yb[6-j]) begin n_fail++; $display("FAIL nonoverlap_b_y step%0d: got %0b expected %0b", j, s_y[1], yb[6-j]); end
            if (s_cs[0] !== 8'(csa[j])) begin n_fail++; $display("FAIL overlap_a_cs step%0d: got %0d expected %0d", j, s_cs[0], csa[j]); end
            if (j == 3) begin
                n_checks++;
                if (s_cs[1] !== 8'd0) begin n_fail++; $display("FAIL nonoverlap_b_cs: got %0d expected 0", s_cs[1]); end
            end
        end
        n_checks += 2;
        if (s_cnt[0] !== 8'd2) begin n_fail++; $display("FAIL overlap_a_cnt: got %0d expected 2", s_cnt[0]); end
        if (s_cnt[1] !== 8'd1) begin n_fail++; $display("FAIL nonoverlap_b_cnt: got %0d expected 1", s_cnt[1]); end
    endtask

    task automatic test_legacy();
        logic [4:0] yc;
        logic [4:0] yd;
        yc = 5'b00111; yd = 5'b00100;
        do_reset();
        for (int j = 0; j < 5; j++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_checks += 5;
                if (s_y[i] !== e_y[i]) begin n_fail++; $display("FAIL legacy_y inst%0d step%0d: got %0b expected %0b", i, j, s_y[i], e_y[i]); end
                if (s_ns[i] !== 8'(e_ns[i])) begin n_fail++; $display("FAIL legacy_ns inst%0d step%0d: got %0d expected %0d", i, j, s_ns[i], e_ns[i]); end
                if (s_cs[i] !== 8'(e_cs[i])) begin n_fail++; $display("FAIL legacy_cs inst%0d step%0d: got %0d expected %0d", i, j, s_cs[i], e_cs[i]); end
                if (s_cnt[i] !== 8'(e_cnt[i])) begin n_fail++; $display("FAIL legacy_cnt inst%0d step%0d: got %0d expected %0d", i, j, s_cnt[i], e_cnt[i]); end
                if (s_sat[i] !== e_sat[i]) begin n_fail++; $display("FAIL legacy_sat inst%0d step%0d: got %0b expected %0b", i, j, s_sat[i], e_sat[i]); end
            end
            n_checks += 2;
            if (s_y[2] !== yc[4-j]) begin n_fail++; $display("FAIL legacy_c_y step%0d: got %0b expected %0b", j, s_y[2], yc[4-j]); end
            if (s_y[3] !== yd[4-j]) begin n_fail++; $display("FAIL legacy_d_y step%0d: got %0b expected %0b", j, s_y[3], yd[4-j]); end
        end
        n_checks += 2;
        if (s_cnt[2] !== 8'd3) begin n_fail++; $display("FAIL legacy_c_cnt: got %0d expected 3", s_cnt[2]); end
        if (s_cnt[3] !== 8'd1) begin n_fail++; $display("FAIL legacy_d_cnt: got %0d expected 1", s_cnt[3]); end
    endtask

    task automatic test_enable_gap();
        logic [6:0]  en_s;
        logic [6:0]  x_s;
        logic [10:0] ya;
        en_s = 7'b1100011; x_s = 7'b1000011;
        ya   = 11'b00000010001;
        do_reset();
        for (int j = 0; j < 12; j++) begin
            if (j < 7) begin
                run_cycle(en_s[6-j], x_s[6-j], 1'b0, 1'b0);
            end else if (j == 7) begin
                pat4 = 4'b0000; pat3 = 3'b000;
                run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
            end else begin
                run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
            end
            for (int i = 0; i < 4; i++) begin
                n_checks += 5;
                if (s_y[i] !== e_y[i]) begin n_fail++; $display("FAIL gap_y inst%0d step%0d: got %0b expected %0b", i, j, s_y[i], e_y[i]); end
                if (s_ns[i] !== 8'(e_ns[i])) begin n_fail++; $display("FAIL gap_ns inst%0d step%0d: got %0d expected %0d", i, j, s_ns[i], e_ns[i]); end
                if (s_cs[i] !== 8'(e_cs[i])) begin n_fail++; $display("FAIL gap_cs inst%0d step%0d: got %0d expected %0d", i, j, s_cs[i], e_cs[i]); end
                if (s_cnt[i] !== 8'(e_cnt[i])) begin n_fail++; $display("FAIL gap_cnt inst%0d step%0d: got %0d expected %0d", i, j, s_cnt[i], e_cnt[i]); end
                if (s_sat[i] !== e_sat[i]) begin n_fail++; $display("FAIL gap_sat inst%0d step%0d: got %0b expected %0b", i, j, s_sat[i], e_sat[i]); end
            end
            if (j != 7) begin
                n_checks++;
                if (s_y[0] !== ya[10 - (j > 7 ? j - 1 : j)]) begin
                    n_fail++; $display("FAIL gap_a_y step%0d: got %0b expected %0b", j, s_y[0], ya[10 - (j > 7 ? j - 1 : j)]);
                end
            end
            if (j >= 2 && j <= 4) begin
                n_checks++;
                if (s_cs[0] !== 8'd2) begin n_fail++; $display("FAIL gap_a_hold step%0d: got %0d expected 2", j, s_cs[0]); end
            end
        end
        n_checks++;
        if (s_cnt[0] !== 8'd2) begin n_fail++; $display("FAIL gap_a_cnt: got %0d expected 2", s_cnt[0]); end
    endtask

    task automatic test_saturation();
        int cc [8];
        logic [7:0] sc;
        cc = '{0, 0, 1, 2, 3, 3, 1, 0};
        sc = 8'b00001100;
        do_reset();
        for (int j = 0; j < 8; j++) begin
            if (j < 6)       run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
            else if (j == 6) run_cycle(1'b1, 1'b1, 1'b0, 1'b1);
            else             run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 4; i++) begin
                n_checks += 5;
                if (s_y[i] !== e_y[i]) begin n_fail++; $display("FAIL sat_y inst%0d step%0d: got %0b expected %0b", i, j, s_y[i], e_y[i]); end
                if (s_ns[i] !== 8'(e_ns[i])) begin n_fail++; $display("FAIL sat_ns inst%0d step%0d: got %0d expected %0d", i, j, s_ns[i], e_ns[i]); end
                if (s_cs[i] !== 8'(e_cs[i])) begin n_fail++; $display("FAIL sat_cs inst%0d step%0d: got %0d expected %0d", i, j, s_cs[i], e_cs[i]); end
                if (s_cnt[i] !== 8'(e_cnt[i])) begin n_fail++; $display("FAIL sat_cnt inst%0d step%0d: got %0d expected %0d", i, j, s_cnt[i], e_cnt[i]); end
                if (s_sat[i] !== e_sat[i]) begin n_fail++; $display("FAIL sat_flag inst%0d step%0d: got %0b expected %0b", i, j, s_sat[i], e_sat[i]); end
            end
            n_checks += 2;
            if (s_cnt[2] !== 8'(cc[j])) begin n_fail++; $display("FAIL sat_c_cnt step%0d: got %0d expected %0d", j, s_cnt[2], cc[j]); end
            if (s_sat[2] !== sc[7-j]) begin n_fail++; $display("FAIL sat_c_flag step%0d: got %0b expected %0b", j, s_sat[2], sc[7-j]); end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        for (int j = 0; j < 4; j++) run_cycle(1'b1, bits[3-j], 1'b0, 1'b0);
        pat4 = 4'b0000; pat3 = 3'b000;
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks += 2;
        if (s_cs[0] !== 8'd3) begin n_fail++; $display("FAIL arst_pre_cs: got %0d expected 3", s_cs[0]); end
        if (s_cnt[0] !== 8'd1) begin n_fail++; $display("FAIL arst_pre_cnt: got %0d expected 1", s_cnt[0]); end
        @(negedge clk);
        en = 1'b1; x = 1'b0;
        #2;
        n_checks++;
        if (obs_y[0] !== 1'b1) begin n_fail++; $display("FAIL arst_pre_y: got %0b expected 1", obs_y[0]); end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks += 4;
            if (obs_y[i] !== 1'b0) begin n_fail++; $display("FAIL arst_y inst%0d: got %0b expected 0", i, obs_y[i]); end
            if (obs_cs[i] !== 8'd0) begin n_fail++; $display("FAIL arst_cs inst%0d: got %0d expected 0", i, obs_cs[i]); end
            if (obs_ns[i] !== 8'd0) begin n_fail++; $display("FAIL arst_ns inst%0d: got %0d expected 0", i, obs_ns[i]); end
            if (obs_cnt[i] !== 8'd0) begin n_fail++; $display("FAIL arst_cnt inst%0d: got %0d expected 0", i, obs_cnt[i]); end
        end
        model_reset();
        pat4 = 4'b1011; pat3 = 3'b111;
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            run_cycle(1'b1, bits[3-j], 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_checks += 5;
                if (s_y[i] !== e_y[i]) begin n_fail++; $display("FAIL arst_post_y inst%0d step%0d: got %0b expected %0b", i, j, s_y[i], e_y[i]); end
                if (s_ns[i] !== 8'(e_ns[i])) begin n_fail++; $display("FAIL arst_post_ns inst%0d step%0d: got %0d expected %0d", i, j, s_ns[i], e_ns[i]); end
                if (s_cs[i] !== 8'(e_cs[i])) begin n_fail++; $display("FAIL arst_post_cs inst%0d step%0d: got %0d expected %0d", i, j, s_cs[i], e_cs[i]); end
                if (s_cnt[i] !== 8'(e_cnt[i])) begin n_fail++; $display("FAIL arst_post_cnt inst%0d step%0d: got %0d expected %0d", i, j, s_cnt[i], e_cnt[i]); end
                if (s_sat[i] !== e_sat[i]) begin n_fail++; $display("FAIL arst_post_sat inst%0d step%0d: got %0b expected %0b", i, j, s_sat[i], e_sat[i]); end
            end
        end
        n_checks++;
        if (s_y[0] !== 1'b1) begin n_fail++; $display("FAIL arst_rst_pat_match: got %0b expected 1", s_y[0]); end
    endtask

    task automatic test_random();
        logic r_en;
        logic r_x;
        logic r_ld;
        logic r_clr;
        do_reset();
        for (int j = 0; j < 400; j++) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_x   = 1'($urandom_range(0, 1));
            r_ld  = ($urandom_range(0, 31) == 0);
            r_clr = ($urandom_range(0, 23) == 0);
            if (r_ld) begin
                pat4 = 4'($urandom_range(0, 15));
                pat3 = 3'($urandom_range(0, 7));
            end
            run_cycle(r_en, r_x, r_ld, r_clr);
            for (int i = 0; i < 4; i++) begin
                n_checks += 5;
                if (s_y[i] !== e_y[i]) begin n_fail++; $display("FAIL rand_y inst%0d step%0d: got %0b expected %0b", i, j, s_y[i], e_y[i]); end
                if (s_ns[i] !== 8'(e_ns[i])) begin n_fail++; $display("FAIL rand_ns inst%0d step%0d: got %0d expected %0d", i, j, s_ns[i], e_ns[i]); end
                if (s_cs[i] !== 8'(e_cs[i])) begin n_fail++; $display("FAIL rand_cs inst%0d step%0d: got %0d expected %0d", i, j, s_cs[i], e_cs[i]); end
                if (s_cnt[i] !== 8'(e_cnt[i])) begin n_fail++; $display("FAIL rand_cnt inst%0d step%0d: got %0d expected %0d", i, j, s_cnt[i], e_cnt[i]); end
                if (s_sat[i] !== e_sat[i]) begin n_fail++; $display("FAIL rand_sat inst%0d step%0d: got %0b expected %0b", i, j, s_sat[i], e_sat[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_legacy();
        test_enable_gap();
        test_saturation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
